// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT sweep unit.
// Optional signature path is enabled by defining LUT_SIG_EN.
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] s,
        input logic             b
    );
        logic [SIG_W-1:0] n;
        n = {s[SIG_W-2:0], 1'b0};
        if (s[SIG_W-1]) n = n ^ SIG_POLY;
        n[0] = n[0] ^ b;
        return n;
    endfunction

endpackage

// File: rtl/lut_sweep_unit_eval.sv
// Truth-table read mux, shared by the single-vector and sweep paths.
// Purely combinational.
module lut_eval
    import lut_sweep_pkg::*;
#(
    parameter int N_IN = 5
) (
    input  logic [2**N_IN-1:0] lut_i,
    input  logic [N_IN-1:0]    sel_i,
    output logic               bit_o
);

    assign bit_o = lut_i[sel_i];

endmodule

// File: rtl/lut_sweep_unit.sv
// Programmable N_IN-input LUT with registered eval and exhaustive sweep.
// Define LUT_SIG_EN to add the 16-bit MISR sweep signature on sig.
module lut_sweep_unit
    import lut_sweep_pkg::*;
#(
    parameter int                N_IN      = 5,
    parameter logic [2**N_IN-1:0] RESET_LUT = 32'hFF404040
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2**N_IN-1:0] cfg_lut,
    input  logic               in_valid,
    input  logic [N_IN-1:0]    in_vec,
    input  logic               start,
    output logic               z,
    output logic               z_valid,
    output logic [N_IN-1:0]    z_vec,
    output logic               busy,
    output logic               done,
    output logic [N_IN:0]      ones_count,
    output logic [SIG_W-1:0]   sig
);

    localparam logic [N_IN-1:0] IDX_LAST = '1;

    state_t              state_q, state_d;
    logic [2**N_IN-1:0]  lut_q, lut_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic                z_q, z_d;
    logic                zv_q, zv_d;
    logic [N_IN-1:0]     zvec_q, zvec_d;
    logic [N_IN:0]       ones_q, ones_d;
    logic [N_IN-1:0]     sel;
    logic                f_bit;
    logic                accept;
    logic                sweep_go;

    assign accept   = (state_q != SWEEP);
    assign sweep_go = accept & start;
    assign sel      = (state_q == SWEEP) ? idx_q : in_vec;

    lut_eval #(.N_IN(N_IN)) u_eval (
        .lut_i (lut_q),
        .sel_i (sel),
        .bit_o (f_bit)
    );

    always_comb begin
        state_d = state_q;
        lut_d   = lut_q;
        idx_d   = idx_q;
        z_d     = z_q;
        zv_d    = 1'b0;
        zvec_d  = zvec_q;
        ones_d  = ones_q;
        unique case (state_q)
            SWEEP: begin
                z_d    = f_bit;
                zv_d   = 1'b1;
                zvec_d = idx_q;
                ones_d = ones_q + {{N_IN{1'b0}}, f_bit};
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = DONE;
            end
            default: begin
                // IDLE and DONE both accept commands; DONE just falls to IDLE
                state_d = IDLE;
                if (cfg_we) lut_d = cfg_lut;
                if (sweep_go) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    ones_d  = '0;
                end else if (in_valid) begin
                    z_d    = f_bit;
                    zv_d   = 1'b1;
                    zvec_d = in_vec;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lut_q   <= RESET_LUT;
            idx_q   <= '0;
            z_q     <= 1'b0;
            zv_q    <= 1'b0;
            zvec_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            lut_q   <= lut_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            zv_q    <= zv_d;
            zvec_q  <= zvec_d;
            ones_q  <= ones_d;
        end
    end

`ifdef LUT_SIG_EN
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (sweep_go) sig_d = '0;
        else if (state_q == SWEEP) sig_d = misr_step(sig_q, f_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

    assign z          = z_q;
    assign z_valid    = zv_q;
    assign z_vec      = zvec_q;
    assign busy       = (state_q == SWEEP);
    assign done       = (state_q == DONE);
    assign ones_count = ones_q;

endmodule

// File: tb/tb_lut_sweep_unit.sv
// Directed self-checking bench for lut_sweep_unit (N_IN = 5).
// Expected signature follows LUT_SIG_EN: MISR model when defined, else 0.
module tb_lut_sweep_unit;

    localparam logic [31:0] RST_LUT = 32'hFF404040;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [31:0] cfg_lut;
    logic        in_valid;
    logic [4:0]  in_vec;
    logic        start;
    logic        z;
    logic        z_valid;
    logic [4:0]  z_vec;
    logic        busy;
    logic        done;
    logic [5:0]  ones_count;
    logic [15:0] sig;

    int checks = 0;
    int errors = 0;

    lut_sweep_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_lut    (cfg_lut),
        .in_valid   (in_valid),
        .in_vec     (in_vec),
        .start      (start),
        .z          (z),
        .z_valid    (z_valid),
        .z_vec      (z_vec),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count),
        .sig        (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] misr_model(input logic [31:0] t);
        logic [15:0] s;
        logic        fb;
        s = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            fb = s[15];
            s  = {s[14:0], 1'b0};
            if (fb) s = s ^ 16'h1021;
            s[0] = s[0] ^ t[i];
        end
        return s;
    endfunction

    function automatic logic [15:0] exp_sig(input logic [31:0] t);
`ifdef LUT_SIG_EN
        return misr_model(t);
`else
        return (t == t) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic idle_inputs();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic eval(input string nm, input logic [4:0] v,
                        input logic exp_z);
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (z_valid !== 1'b1 || z !== exp_z || z_vec !== v) begin
            errors++;
            $display("FAIL %s: zv=%b z=%b vec=%h want zv=1 z=%b vec=%h",
                     nm, z_valid, z, z_vec, exp_z, v);
        end
    endtask

    task automatic load(input logic [31:0] t);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_lut = t;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic run_sweep(input string nm, input logic [31:0] t,
                             input int exp_ones, input logic [15:0] es,
                             input bit noise);
        int  busy_n;
        int  zv_n;
        int  vec_err;
        bit  seen;
        busy_n  = 0;
        zv_n    = 0;
        vec_err = 0;
        seen    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (busy) busy_n++;
            if (z_valid) begin
                if (zv_n > 31 || z_vec !== zv_n[4:0] || z !== t[zv_n % 32])
                    vec_err++;
                zv_n++;
            end
            if (done) seen = 1'b1;
            if (!seen) begin
                if (noise && busy_n >= 2 && busy_n < 28) begin
                    in_valid = 1'b1;
                    in_vec   = 5'd7;
                    cfg_we   = 1'b1;
                    cfg_lut  = 32'h0;
                    start    = 1'b1;
                end else begin
                    idle_inputs();
                end
                @(negedge clk);
            end
        end
        idle_inputs();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within 60 cycles", nm);
        end
        checks++;
        if (busy_n != 32) begin
            errors++;
            $display("FAIL %s_busy: %0d cycles want 32", nm, busy_n);
        end
        checks++;
        if (zv_n != 32 || vec_err != 0) begin
            errors++;
            $display("FAIL %s_vec: %0d pulses %0d bad want 32 0",
                     nm, zv_n, vec_err);
        end
        checks++;
        if (ones_count !== exp_ones[5:0]) begin
            errors++;
            $display("FAIL %s_ones: %0d want %0d", nm, ones_count, exp_ones);
        end
        checks++;
        if (sig !== es) begin
            errors++;
            $display("FAIL %s_sig: %h want %h", nm, sig, es);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ones_count !== exp_ones[5:0]) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b ones=%0d want 0 0 %0d",
                     nm, done, busy, ones_count, exp_ones);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_lut = 32'h0;
        in_vec  = 5'h0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({z, z_valid, z_vec, busy, done, ones_count, sig} !== '0) begin
            errors++;
            $display("FAIL reset: z=%b zv=%b vec=%h busy=%b done=%b ones=%0d sig=%h want all 0",
                     z, z_valid, z_vec, busy, done, ones_count, sig);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_eval();
        eval("eval_11000", 5'b11000, 1'b1);
        eval("eval_00110", 5'b00110, 1'b1);
        eval("eval_00111", 5'b00111, 1'b0);
        @(negedge clk);
        checks++;
        if (z_valid !== 1'b0) begin
            errors++;
            $display("FAIL eval_pulse: z_valid=%b want 0", z_valid);
        end
    endtask

    task automatic test_cfg_same_cycle();
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_lut  = 32'h0;
        in_valid = 1'b1;
        in_vec   = 5'd24;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (z_valid !== 1'b1 || z !== 1'b1) begin
            errors++;
            $display("FAIL cfg_old_lut: zv=%b z=%b want 1 1", z_valid, z);
        end
        eval("cfg_new_lut", 5'd24, 1'b0);
        load(RST_LUT);
    endtask

    task automatic test_start_priority();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_vec   = 5'd24;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (z_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_prio: zv=%b busy=%b want 0 1", z_valid, busy);
        end
        for (int c = 0; c < 60 && !done; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_sweep();
        run_sweep("sweep_rst", RST_LUT, 11, exp_sig(RST_LUT), 1'b0);
    endtask

    task automatic test_sweep_bounds();
        load(32'hFFFFFFFF);
        run_sweep("sweep_ones", 32'hFFFFFFFF, 32, exp_sig(32'hFFFFFFFF), 1'b0);
        load(32'h0);
        run_sweep("sweep_zero", 32'h0, 0, 16'h0000, 1'b0);
        load(32'hA5A5A5A5);
        run_sweep("sweep_a5", 32'hA5A5A5A5, 16, exp_sig(32'hA5A5A5A5), 1'b0);
        load(RST_LUT);
    endtask

    task automatic test_busy_ignore();
        run_sweep("busy_ign", RST_LUT, 11, exp_sig(RST_LUT), 1'b1);
        eval("busy_lut_kept", 5'd24, 1'b1);
    endtask

    task automatic test_reset_mid();
        load(32'hFFFFFFFF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || z_valid !== 1'b0 || ones_count !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b zv=%b ones=%0d want 0 0 0",
                     busy, z_valid, ones_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        eval("rst_mid_lut", 5'd7, 1'b0);
        run_sweep("rst_mid_sweep", RST_LUT, 11, exp_sig(RST_LUT), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_eval();
        test_cfg_same_cycle();
        test_start_priority();
        test_sweep();
        test_sweep_bounds();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
